lb_window_ctrl: RTL

Sequencing controller for the 3-row pixel line buffer in the Canny front end. It accepts a raster pixel stream through a valid/ready handshake and drives the buffer's load strobe, pixel bus and clear. It tracks column and row position and tells the downstream 3x3 window stage (Gaussian/Sobel) when a buffered column holds three valid rows. It also frames each image with busy and done indications.

---
 rtl/canny_pkg.sv | 16 +
 rtl/raster_counter.sv | 49 ++++
 rtl/lb_window_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types and image constants for the Canny front end
package canny_pkg;

    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;
    localparam int PIX_W      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FILL   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } canny_state_t;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - column/row raster position counter with end-of-line and last-pixel flags
module raster_counter
    import canny_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_adv,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_eol,
    output logic             o_last
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_eol  = (r_col == LAST_COL);
    assign o_last = o_eol && (r_row == LAST_ROW);

    // Position of the next pixel; wraps at the line and frame ends so it never exceeds the image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (o_eol) begin
                r_col <= '0;
                r_row <= o_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lb_window_ctrl.sv
// rtl/lb_window_ctrl.sv - line buffer sequencing and 3x3 window-valid generation
module lb_window_ctrl
    import canny_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             lb_rst,
    output logic             lb_ld,
    output logic [PIX_W-1:0] lb_pixel,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             win_valid,
    output logic             win_border,
    output logic             busy,
    output logic             frame_done
);

    canny_state_t     r_state;
    canny_state_t     w_next;
    logic             w_accept;
    logic [COL_W-1:0] w_cur_col;
    logic [ROW_W-1:0] w_cur_row;
    logic             w_eol;
    logic             w_last;
    logic             w_win;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_win_valid;
    logic             r_win_border;

    // Acceptance derives from state directly so it does not loop through in_ready
    assign w_accept = in_valid && ((r_state == FILL) || (r_state == STREAM));
    assign lb_ld    = w_accept;
    assign lb_pixel = in_pixel;
    assign w_win    = w_accept && (r_state == STREAM) &&
                      (w_cur_row >= ROW_W'(2)) && (w_cur_col >= COL_W'(2));

    assign col        = r_col;
    assign row        = r_row;
    assign win_valid  = r_win_valid;
    assign win_border = r_win_border;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_state == CLEAR),
        .i_adv   (w_accept),
        .o_col   (w_cur_col),
        .o_row   (w_cur_row),
        .o_eol   (w_eol),
        .o_last  (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and framing outputs
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        lb_rst     = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = CLEAR;
            end
            CLEAR: begin
                lb_rst = 1'b1;
                busy   = 1'b1;
                w_next = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_eol && (w_cur_row == ROW_W'(1))) w_next = STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_last) w_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                busy       = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Report the accepted pixel's position and flag full windows in step with the buffer's output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_win_border <= 1'b0;
        end else begin
            r_win_valid  <= w_win;
            r_win_border <= w_win && (w_cur_col == COL_W'(2));
            if (r_state == CLEAR) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                r_col <= w_cur_col;
                r_row <= w_cur_row;
            end
        end
    end

endmodule
